// File: rtl/z80_irq_ctrl.sv
// Z80 mode-2 daisy-chain interrupt controller: edge/level detect, mask, fixed priority, in-service tracking.
// Define Z80_IRQ_CTRL_VBASE_EN to make register 4 (VBASE) a programmable vector base.
module z80_irq_ctrl #(
  parameter int unsigned          NUM_SRC   = 4,
  parameter logic [2*NUM_SRC-1:0] EDGE_MODE = '0,
  parameter logic [63:0]          VEC_TABLE = 64'h0000_0000_080A_0C0E,
  parameter bit                   SYNC      = 1'b1
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic [NUM_SRC-1:0] src_i,
  input  logic               cs_n,
  input  logic               rd_n,
  input  logic               wr_n,
  input  logic [2:0]         addr,
  input  logic [7:0]         din,
  output logic [7:0]         dout,
  input  logic               m1_n,
  input  logic               iorq_n,
  input  logic               reti,
  input  logic               iei,
  output logic               ieo,
  output logic               int_n,
  output logic [7:0]         vec_o,
  output logic               vec_oe
);

  localparam logic [2:0] REG_MASK  = 3'd0;
  localparam logic [2:0] REG_PEND  = 3'd1;
  localparam logic [2:0] REG_INSV  = 3'd2;
  localparam logic [2:0] REG_STAT  = 3'd3;
  localparam logic [2:0] REG_VBASE = 3'd4;
  localparam logic [7:0] CH_MASK   = 8'((9'd1 << NUM_SRC) - 9'd1);

  function automatic logic [7:0] lowest_oh(input logic [7:0] v);
    return v & (~v + 8'd1);
  endfunction

  function automatic logic [2:0] oh_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++)
      if (oh[i]) idx = 3'(i);
    return idx;
  endfunction

  logic [NUM_SRC-1:0] src_s, src_d;
  logic [7:0] evt, lvl_ch, lvl_val;
  logic [7:0] mask, pending, in_service, allow, req, win_oh;
  logic [7:0] mask_nxt, pend_nxt, insv_nxt, win_vec;
  logic [2:0] win, win_nxt;
  logic       ack, ack_d, ack_take, ack_act, ack_act_nxt;
  logic       wr_d, wr_stb, int_n_nxt;

  if (SYNC) begin : g_sync
    logic [NUM_SRC-1:0] sync1, sync2;
    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
        sync1 <= '0;
        sync2 <= '0;
      end else begin
        sync1 <= src_i;
        sync2 <= sync1;
      end
    end
    assign src_s = sync2;
  end else begin : g_nosync
    assign src_s = src_i;
  end

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    evt     = '0;
    lvl_ch  = '0;
    lvl_val = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      case (EDGE_MODE[2*i +: 2])
        2'b00:   evt[i] = src_s[i] & ~src_d[i];
        2'b01:   evt[i] = ~src_s[i] & src_d[i];
        2'b10:   evt[i] = src_s[i] ^ src_d[i];
        default: begin
          lvl_ch[i]  = 1'b1;
          lvl_val[i] = src_s[i];
        end
      endcase
    end
  end

  assign ack      = ~m1_n & ~iorq_n;
  assign ack_take = ack & ~ack_d & ~int_n;
  assign wr_stb   = ~cs_n & ~wr_n & ~wr_d;
  // Subtracting one from the lowest in-service one-hot leaves only strictly higher-priority
  // channels; with nothing in service it wraps to all ones.
  assign allow    = lowest_oh(in_service) - 8'd1;
  assign req      = pending & ~mask & allow;
  assign win_oh   = lowest_oh(req);

  always_comb begin
    mask_nxt = mask;
    pend_nxt = pending;
    insv_nxt = in_service;
    win_nxt  = win;
    if (wr_stb && addr == REG_MASK) mask_nxt = din | ~CH_MASK;
    if (wr_stb && addr == REG_PEND) pend_nxt = pend_nxt & ~din;
    if (ack_take) begin
      insv_nxt = insv_nxt | win_oh;
      pend_nxt = pend_nxt & ~win_oh;
      if (|req) win_nxt = oh_to_idx(win_oh);
    end
    // A new event beats a same-cycle clear; level channels simply mirror the input.
    pend_nxt = ((pend_nxt | evt) & ~lvl_ch) | lvl_val;
    if (reti) insv_nxt = insv_nxt & ~lowest_oh(insv_nxt);
    ack_act_nxt = ack & (ack_act | ack_take);
    int_n_nxt   = ack_take | ~(iei & |req);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      src_d      <= '0;
      mask       <= 8'hFF;
      pending    <= '0;
      in_service <= '0;
      win        <= '0;
      ack_d      <= 1'b0;
      ack_act    <= 1'b0;
      wr_d       <= 1'b0;
      int_n      <= 1'b1;
    end else begin
      src_d      <= src_s;
      mask       <= mask_nxt;
      pending    <= pend_nxt;
      in_service <= insv_nxt;
      win        <= win_nxt;
      ack_d      <= ack;
      ack_act    <= ack_act_nxt;
      wr_d       <= ~cs_n & ~wr_n;
      int_n      <= int_n_nxt;
    end
  end

`ifdef Z80_IRQ_CTRL_VBASE_EN
  logic [3:0] vbase_hi;
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)                          vbase_hi <= VEC_TABLE[7:4];
    else if (wr_stb && addr == REG_VBASE)  vbase_hi <= din[7:4];
  end
  assign win_vec = {vbase_hi, win, 1'b0};
`else
  assign win_vec = VEC_TABLE[8*win +: 8];
`endif

  assign vec_oe = ack_act & ack;
  assign vec_o  = vec_oe ? win_vec : 8'hFF;
  assign ieo    = iei & ~|in_service & int_n;

  always_comb begin
    dout = 8'hFF;
    if (~cs_n & ~rd_n) begin
      case (addr)
        REG_MASK:  dout = mask & CH_MASK;
        REG_PEND:  dout = pending;
        REG_INSV:  dout = in_service;
        REG_STAT:  dout = {~int_n, 3'b000, vec_oe, win};
`ifdef Z80_IRQ_CTRL_VBASE_EN
        REG_VBASE: dout = {vbase_hi, 4'h0};
`endif
        default:   dout = 8'hFF;
      endcase
    end
  end

endmodule

// File: tb/tb_z80_irq_ctrl.sv
// Self-checking bench for z80_irq_ctrl: scenario tasks with a vector/status scoreboard.
// Eight channels: 0-3 rising, 4 falling, 5 both edges, 6 level, 7 rising.
module tb_z80_irq_ctrl;

  localparam logic [63:0] TB_VEC  = 64'h3836_3432_080A_0C0E;
  localparam logic [15:0] TB_EDGE = 16'h3900;

  logic       clk_sys = 1'b0;
  logic       reset_n;
  logic [7:0] src_i;
  logic       cs_n, rd_n, wr_n, m1_n, iorq_n, reti, iei;
  logic [2:0] addr;
  logic [7:0] din, dout, vec_o;
  logic       ieo, int_n, vec_oe;

  typedef struct packed {
    logic [7:0] vec;
    logic [7:0] stat;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
`ifdef Z80_IRQ_CTRL_VBASE_EN
  logic [7:0] vbase_m = TB_VEC[7:0] & 8'hF0;
`endif

  z80_irq_ctrl #(.NUM_SRC(8), .EDGE_MODE(TB_EDGE), .VEC_TABLE(TB_VEC), .SYNC(1'b1)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .src_i(src_i), .cs_n(cs_n), .rd_n(rd_n),
    .wr_n(wr_n), .addr(addr), .din(din), .dout(dout), .m1_n(m1_n), .iorq_n(iorq_n),
    .reti(reti), .iei(iei), .ieo(ieo), .int_n(int_n), .vec_o(vec_o), .vec_oe(vec_oe)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish, required completion before 100us");
    $fatal(1);
  end

  function automatic logic [7:0] vec_model(input int ch);
`ifdef Z80_IRQ_CTRL_VBASE_EN
    return {vbase_m[7:4], 3'(ch), 1'b0};
`else
    logic [63:0] t;
    t = TB_VEC;
    return t[8*ch +: 8];
`endif
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic reg_write(input logic [2:0] a, input logic [7:0] d);
    cs_n = 1'b0; wr_n = 1'b0; addr = a; din = d;
    tick(1);
    cs_n = 1'b1; wr_n = 1'b1;
    tick(1);
  endtask

  task automatic reg_read(input logic [2:0] a, output logic [7:0] d);
    cs_n = 1'b0; rd_n = 1'b0; addr = a;
    #1;
    d = dout;
    cs_n = 1'b1; rd_n = 1'b1;
  endtask

  task automatic wait_int_low(input int budget, output int n);
    n = 0;
    while (int_n !== 1'b0 && n < budget) begin
      tick(1);
      n++;
    end
  endtask

  task automatic pulse_reti();
    reti = 1'b1;
    tick(1);
    reti = 1'b0;
  endtask

  task automatic do_ack(input int ch);
    exp_t e;
    logic [7:0] d;
    bit got;
    e.vec  = vec_model(ch);
    e.stat = {1'b0, 3'b000, 1'b1, 3'(ch)};
    exp_q.push_back(e);
    m1_n = 1'b0; iorq_n = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 3 && !got; i++) begin
      tick(1);
      if (vec_oe === 1'b1) got = 1'b1;
    end
    e = exp_q.pop_front();
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL ack_vec_oe ch%0d vec_oe=%b required 1", ch, vec_oe);
    end else begin
      checks++;
      if (vec_o !== e.vec) begin
        errors++;
        $display("FAIL ack_vector ch%0d got %h required %h", ch, vec_o, e.vec);
      end
      reg_read(3'd3, d);
      checks++;
      if (d !== e.stat) begin
        errors++;
        $display("FAIL ack_stat ch%0d got %h required %h", ch, d, e.stat);
      end
    end
    m1_n = 1'b1; iorq_n = 1'b1;
    #1;
    checks++;
    if (vec_oe !== 1'b0) begin
      errors++;
      $display("FAIL ack_release ch%0d vec_oe=%b required 0", ch, vec_oe);
    end
    tick(1);
  endtask

  task automatic test_reset();
    logic [7:0] d;
    reset_n = 1'b0; src_i = '0; cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    m1_n = 1'b1; iorq_n = 1'b1; reti = 1'b0; iei = 1'b1; addr = '0; din = '0;
    tick(3);
    checks++;
    if ({int_n, ieo, vec_oe, vec_o, dout} !== {1'b1, 1'b1, 1'b0, 8'hFF, 8'hFF}) begin
      errors++;
      $display("FAIL reset_outputs got int_n=%b ieo=%b vec_oe=%b vec_o=%h dout=%h required 1 1 0 ff ff",
               int_n, ieo, vec_oe, vec_o, dout);
    end
    reset_n = 1'b1;
    tick(1);
    reg_read(3'd0, d);
    checks++;
    if (d !== 8'hFF) begin errors++; $display("FAIL reset_mask got %h required ff", d); end
    reg_read(3'd1, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL reset_pend got %h required 00", d); end
  endtask

  task automatic test_mask();
    logic [7:0] d;
    src_i[0] = 1'b1;
    tick(6);
    reg_read(3'd1, d);
    checks++;
    if (d !== 8'h01) begin errors++; $display("FAIL masked_pend got %h required 01", d); end
    checks++;
    if (int_n !== 1'b1) begin errors++; $display("FAIL masked_int_n got %b required 1", int_n); end
    reg_write(3'd0, 8'hFE);
    checks++;
    if (int_n !== 1'b0) begin errors++; $display("FAIL unmask_int_n got %b required 0", int_n); end
    do_ack(0);
    pulse_reti();
    reg_read(3'd2, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL mask_insv_clear got %h required 00", d); end
  endtask

  task automatic test_priority();
    logic [7:0] d;
    int n;
    src_i[0] = 1'b0;
    tick(4);
    reg_write(3'd0, 8'h00);
    src_i[1:0] = 2'b11;
    wait_int_low(8, n);
    checks++;
    if (n !== 4) begin errors++; $display("FAIL latency got %0d cycles required 4", n); end
    do_ack(0);
    reg_read(3'd2, d);
    checks++;
    if (d !== 8'h01) begin errors++; $display("FAIL prio_insv got %h required 01", d); end
    reg_read(3'd1, d);
    checks++;
    if (d !== 8'h02) begin errors++; $display("FAIL prio_pend got %h required 02", d); end
    tick(3);
    checks++;
    if (int_n !== 1'b1) begin errors++; $display("FAIL prio_blocked int_n got %b required 1", int_n); end
    pulse_reti();
    wait_int_low(4, n);
    checks++;
    if (int_n !== 1'b0) begin errors++; $display("FAIL prio_after_reti int_n got %b required 0", int_n); end
    do_ack(1);
  endtask

  task automatic test_nesting();
    logic [7:0] d;
    int n;
    src_i[0] = 1'b0;
    tick(4);
    src_i[0] = 1'b1;
    wait_int_low(8, n);
    checks++;
    if ({int_n, ieo} !== 2'b00) begin
      errors++;
      $display("FAIL nest_request got int_n=%b ieo=%b required 0 0", int_n, ieo);
    end
    do_ack(0);
    reg_read(3'd2, d);
    checks++;
    if (d !== 8'h03) begin errors++; $display("FAIL nest_insv got %h required 03", d); end
    pulse_reti();
    reg_read(3'd2, d);
    checks++;
    if (d !== 8'h02) begin errors++; $display("FAIL nest_reti1 got %h required 02", d); end
    pulse_reti();
    reg_read(3'd2, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL nest_reti2 got %h required 00", d); end
    pulse_reti();
    tick(1);
    reg_read(3'd2, d);
    checks++;
    if ({d, ieo} !== {8'h00, 1'b1}) begin
      errors++;
      $display("FAIL nest_idle got insv=%h ieo=%b required 00 1", d, ieo);
    end
  endtask

  task automatic test_daisy();
    iei = 1'b0;
    src_i[2] = 1'b1;
    tick(6);
    checks++;
    if ({int_n, ieo} !== 2'b10) begin
      errors++;
      $display("FAIL daisy_blocked got int_n=%b ieo=%b required 1 0", int_n, ieo);
    end
    iei = 1'b1;
    tick(1);
    checks++;
    if (int_n !== 1'b0) begin errors++; $display("FAIL daisy_release int_n got %b required 0", int_n); end
    do_ack(2);
    pulse_reti();
  endtask

  task automatic test_foreign_ack_and_reset();
    logic [7:0] d;
    exp_t e;
    int n;
    m1_n = 1'b0; iorq_n = 1'b0;
    tick(2);
    checks++;
    if (vec_oe !== 1'b0) begin errors++; $display("FAIL foreign_vec_oe got %b required 0", vec_oe); end
    m1_n = 1'b1; iorq_n = 1'b1;
    tick(1);
    reg_read(3'd2, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL foreign_insv got %h required 00", d); end
    src_i[3] = 1'b1;
    wait_int_low(8, n);
    e.vec = vec_model(3);
    e.stat = 8'h0B;
    exp_q.push_back(e);
    m1_n = 1'b0; iorq_n = 1'b0;
    tick(1);
    e = exp_q.pop_front();
    checks++;
    if ({vec_oe, vec_o} !== {1'b1, e.vec}) begin
      errors++;
      $display("FAIL midack_vector got oe=%b vec=%h required 1 %h", vec_oe, vec_o, e.vec);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({vec_oe, int_n, vec_o} !== {1'b0, 1'b1, 8'hFF}) begin
      errors++;
      $display("FAIL midack_reset got vec_oe=%b int_n=%b vec_o=%h required 0 1 ff", vec_oe, int_n, vec_o);
    end
    m1_n = 1'b1; iorq_n = 1'b1;
    tick(2);
    reset_n = 1'b1;
`ifdef Z80_IRQ_CTRL_VBASE_EN
    vbase_m = TB_VEC[7:0] & 8'hF0;
`endif
    tick(1);
    reg_read(3'd0, d);
    checks++;
    if (d !== 8'hFF) begin errors++; $display("FAIL reset_ack_mask got %h required ff", d); end
    tick(6);
    reg_write(3'd1, 8'hFF);
    reg_read(3'd1, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL pend_w1c got %h required 00", d); end
  endtask

  task automatic test_edge_modes();
    logic [7:0] d;
    logic [7:0] exp_tab [6];
    exp_tab = '{8'h00, 8'h10, 8'h20, 8'h20, 8'h40, 8'h00};
    for (int s = 0; s < 6; s++) begin
      case (s)
        0: src_i[4] = 1'b1;
        1: src_i[4] = 1'b0;
        2: src_i[5] = 1'b1;
        3: src_i[5] = 1'b0;
        4: src_i[6] = 1'b1;
        default: src_i[6] = 1'b0;
      endcase
      tick(6);
      if (s == 4) reg_write(3'd1, 8'h40);
      reg_read(3'd1, d);
      checks++;
      if (d !== exp_tab[s]) begin
        errors++;
        $display("FAIL edge_mode step%0d pend got %h required %h", s, d, exp_tab[s]);
      end
      reg_write(3'd1, 8'h30);
    end
  endtask

  task automatic test_ack_reti_same_cycle();
    logic [7:0] d;
    exp_t e;
    int n;
    reg_write(3'd0, 8'hFE);
    src_i[0] = 1'b0;
    tick(4);
    src_i[0] = 1'b1;
    wait_int_low(8, n);
    e.vec = vec_model(0);
    e.stat = 8'h08;
    exp_q.push_back(e);
    m1_n = 1'b0; iorq_n = 1'b0; reti = 1'b1;
    tick(1);
    reti = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if ({vec_oe, vec_o} !== {1'b1, e.vec}) begin
      errors++;
      $display("FAIL ack_reti_vector got oe=%b vec=%h required 1 %h", vec_oe, vec_o, e.vec);
    end
    m1_n = 1'b1; iorq_n = 1'b1;
    tick(1);
    reg_read(3'd2, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL ack_reti_insv got %h required 00", d); end
  endtask

  task automatic test_regs();
    logic [7:0] d;
    int n;
    reg_write(3'd5, 8'h00);
    for (int a = 5; a < 8; a++) begin
      reg_read(3'(a), d);
      checks++;
      if (d !== 8'hFF) begin errors++; $display("FAIL unused_reg%0d got %h required ff", a, d); end
    end
`ifdef Z80_IRQ_CTRL_VBASE_EN
    reg_write(3'd4, 8'h40);
    vbase_m = 8'h40;
    reg_read(3'd4, d);
    checks++;
    if (d !== 8'h40) begin errors++; $display("FAIL vbase_read got %h required 40", d); end
    reg_write(3'd0, 8'hF7);
    src_i[3] = 1'b0;
    tick(4);
    src_i[3] = 1'b1;
    wait_int_low(8, n);
    do_ack(3);
    pulse_reti();
`else
    n = 0;
    reg_write(3'd4, 8'h40);
    reg_read(3'd4, d);
    checks++;
    if (d !== 8'hFF) begin errors++; $display("FAIL vbase_absent got %h required ff (waited %0d)", d, n); end
`endif
  endtask

  initial begin
    test_reset();
    test_mask();
    test_priority();
    test_nesting();
    test_daisy();
    test_foreign_ack_and_reset();
    test_edge_modes();
    test_ack_reti_same_cycle();
    test_regs();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
